// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that funnels NUM_FU write-back requesters into one
// registered register-file write port and emits the scoreboard clear pulse.
module wb_port_arbiter #(
   parameter int NUM_FU     = 4,
   parameter int NUM_REG    = 8,
   parameter int REG_BIT    = 16,
   parameter int REG_ID_BIT = $clog2(NUM_REG),
   parameter int FU_ID_BIT  = $clog2(NUM_FU)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_FU-1:0]            fu_wr_vld,
   output logic [NUM_FU-1:0]            fu_wr_rdy,
   input  logic [NUM_FU*REG_ID_BIT-1:0] fu_wr_reg_id,
   input  logic [NUM_FU*REG_BIT-1:0]    fu_wr_data,
   output logic                         rf_wr_vld,
   input  logic                         rf_wr_rdy,
   output logic [REG_ID_BIT-1:0]        rf_wr_reg_id,
   output logic [REG_BIT-1:0]           rf_wr_data,
   output logic [FU_ID_BIT-1:0]         rf_wr_fu,
   output logic [NUM_REG-1:0]           wb_reg_mask,
   output logic [15:0]                  grant_cnt
);

   logic                  load_en;
   logic                  grant_vld;
   logic [FU_ID_BIT-1:0]  grant_idx;
   logic [FU_ID_BIT-1:0]  rr_ptr;
   logic [FU_ID_BIT-1:0]  next_ptr;
   logic                  accept;
   logic [REG_ID_BIT-1:0] grant_reg_id;
   logic [REG_BIT-1:0]    grant_data;

   assign load_en = !rf_wr_vld || rf_wr_rdy;

   // Scan requesters starting at rr_ptr; the first valid one wins.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_FU) begin
            idx = idx - NUM_FU;
         end
         if (!grant_vld && fu_wr_vld[FU_ID_BIT'(idx)]) begin
            grant_vld = 1'b1;
            grant_idx = FU_ID_BIT'(idx);
         end
      end
   end

   always_comb begin
      fu_wr_rdy = '0;
      if (grant_vld) begin
         fu_wr_rdy[grant_idx] = load_en;
      end
   end

   assign accept       = grant_vld && load_en;
   assign grant_reg_id = fu_wr_reg_id[grant_idx*REG_ID_BIT +: REG_ID_BIT];
   assign grant_data   = fu_wr_data[grant_idx*REG_BIT +: REG_BIT];
   assign next_ptr     = (grant_idx == FU_ID_BIT'(NUM_FU - 1)) ? '0
                                                               : grant_idx + FU_ID_BIT'(1);

   // Register 0 is a null destination: the request is consumed but nothing is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_vld    <= 1'b0;
         rf_wr_reg_id <= '0;
         rf_wr_data   <= '0;
         rf_wr_fu     <= '0;
         rr_ptr       <= '0;
      end else if (accept) begin
         rr_ptr <= next_ptr;
         if (grant_reg_id != '0) begin
            rf_wr_vld    <= 1'b1;
            rf_wr_reg_id <= grant_reg_id;
            rf_wr_data   <= grant_data;
            rf_wr_fu     <= grant_idx;
         end else begin
            rf_wr_vld <= 1'b0;
         end
      end else if (rf_wr_rdy) begin
         rf_wr_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else if (rf_wr_vld && rf_wr_rdy && (grant_cnt != 16'hFFFF)) begin
         grant_cnt <= grant_cnt + 16'd1;
      end
   end

   always_comb begin
      wb_reg_mask = '0;
      if (rf_wr_vld && rf_wr_rdy) begin
         wb_reg_mask[rf_wr_reg_id] = 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: a table of per-cycle vectors plus
// hand-written reset-under-stall and counter saturation sequences.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  fu_wr_vld;
   logic [3:0]  fu_wr_rdy;
   logic [11:0] fu_wr_reg_id;
   logic [63:0] fu_wr_data;
   logic        rf_wr_vld;
   logic        rf_wr_rdy;
   logic [2:0]  rf_wr_reg_id;
   logic [15:0] rf_wr_data;
   logic [1:0]  rf_wr_fu;
   logic [7:0]  wb_reg_mask;
   logic [15:0] grant_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fu_wr_vld    (fu_wr_vld),
      .fu_wr_rdy    (fu_wr_rdy),
      .fu_wr_reg_id (fu_wr_reg_id),
      .fu_wr_data   (fu_wr_data),
      .rf_wr_vld    (rf_wr_vld),
      .rf_wr_rdy    (rf_wr_rdy),
      .rf_wr_reg_id (rf_wr_reg_id),
      .rf_wr_data   (rf_wr_data),
      .rf_wr_fu     (rf_wr_fu),
      .wb_reg_mask  (wb_reg_mask),
      .grant_cnt    (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  vld;
      logic [11:0] ids;
      logic [63:0] data;
      logic        rdy;
      logic [3:0]  e_rdy;
      logic        e_vld;
      logic [2:0]  e_reg;
      logic [15:0] e_data;
      logic [1:0]  e_fu;
      logic [7:0]  e_mask;
      logic [15:0] e_cnt;
   } vec_t;

   localparam logic [11:0] IDS_ALL  = {3'd4, 3'd3, 3'd2, 3'd1};
   localparam logic [63:0] DATA_ALL = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
   localparam logic [11:0] IDS_T1   = {3'd0, 3'd5, 3'd0, 3'd0};
   localparam logic [63:0] DATA_T1  = {16'h0000, 16'hA5A5, 16'h0000, 16'h0000};
   localparam logic [11:0] IDS_R6   = {3'd6, 3'd0, 3'd0, 3'd0};
   localparam logic [63:0] DATA_R6  = {16'h6666, 16'h0000, 16'h0000, 16'h0000};
   localparam logic [11:0] IDS_T4   = {3'd7, 3'd0, 3'd0, 3'd0};
   localparam logic [63:0] DATA_T4  = {16'h7777, 16'h0000, 16'hDEAD, 16'h0000};
   localparam logic [11:0] IDS_T5   = {3'd0, 3'd0, 3'd0, 3'd3};
   localparam logic [63:0] DATA_T5  = {16'h0000, 16'h0000, 16'h0000, 16'hBEEF};

   vec_t vecs[17];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] vld, input logic [11:0] ids,
                                input logic [63:0] data, input logic rdy);
      fu_wr_vld    = vld;
      fu_wr_reg_id = ids;
      fu_wr_data   = data;
      rf_wr_rdy    = rdy;
   endtask

   initial begin
      // single grant, then all four FUs rotating
      vecs[0]  = '{4'b0100, IDS_T1,  DATA_T1,  1'b1, 4'b0100, 1'b0, 3'd0, 16'h0000, 2'd0, 8'b0000_0000, 16'd0};
      vecs[1]  = '{4'b0000, IDS_T1,  DATA_T1,  1'b1, 4'b0000, 1'b1, 3'd5, 16'hA5A5, 2'd2, 8'b0010_0000, 16'd0};
      vecs[2]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b1000, 1'b0, 3'd0, 16'h0000, 2'd0, 8'b0000_0000, 16'd1};
      vecs[3]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b0001, 1'b1, 3'd4, 16'h4444, 2'd3, 8'b0001_0000, 16'd1};
      vecs[4]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b0010, 1'b1, 3'd1, 16'h1111, 2'd0, 8'b0000_0010, 16'd2};
      vecs[5]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b0100, 1'b1, 3'd2, 16'h2222, 2'd1, 8'b0000_0100, 16'd3};
      vecs[6]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b1000, 1'b1, 3'd3, 16'h3333, 2'd2, 8'b0000_1000, 16'd4};
      vecs[7]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b0001, 1'b1, 3'd4, 16'h4444, 2'd3, 8'b0001_0000, 16'd5};
      // stall for three cycles, then drain and reload in one cycle
      vecs[8]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b0, 4'b0000, 1'b1, 3'd1, 16'h1111, 2'd0, 8'b0000_0000, 16'd6};
      vecs[9]  = '{4'b1111, IDS_ALL, DATA_ALL, 1'b0, 4'b0000, 1'b1, 3'd1, 16'h1111, 2'd0, 8'b0000_0000, 16'd6};
      vecs[10] = '{4'b1111, IDS_ALL, DATA_ALL, 1'b0, 4'b0000, 1'b1, 3'd1, 16'h1111, 2'd0, 8'b0000_0000, 16'd6};
      vecs[11] = '{4'b1111, IDS_ALL, DATA_ALL, 1'b1, 4'b0010, 1'b1, 3'd1, 16'h1111, 2'd0, 8'b0000_0010, 16'd6};
      vecs[12] = '{4'b0000, IDS_ALL, DATA_ALL, 1'b1, 4'b0000, 1'b1, 3'd2, 16'h2222, 2'd1, 8'b0000_0100, 16'd7};
      // move pointer back to 0, then null write from FU1 ahead of FU3
      vecs[13] = '{4'b1000, IDS_R6,  DATA_R6,  1'b1, 4'b1000, 1'b0, 3'd0, 16'h0000, 2'd0, 8'b0000_0000, 16'd8};
      vecs[14] = '{4'b1010, IDS_T4,  DATA_T4,  1'b1, 4'b0010, 1'b1, 3'd6, 16'h6666, 2'd3, 8'b0100_0000, 16'd8};
      vecs[15] = '{4'b1000, IDS_T4,  DATA_T4,  1'b1, 4'b1000, 1'b0, 3'd0, 16'h0000, 2'd0, 8'b0000_0000, 16'd9};
      vecs[16] = '{4'b0000, IDS_T4,  DATA_T4,  1'b1, 4'b0000, 1'b1, 3'd7, 16'h7777, 2'd3, 8'b1000_0000, 16'd9};

      rst_n = 1'b0;
      applyStimulus(4'b0000, 12'h000, 64'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset rf_wr_vld",    64'(rf_wr_vld),    64'h0);
      checkOutput("reset rf_wr_reg_id", 64'(rf_wr_reg_id), 64'h0);
      checkOutput("reset rf_wr_data",   64'(rf_wr_data),   64'h0);
      checkOutput("reset rf_wr_fu",     64'(rf_wr_fu),     64'h0);
      checkOutput("reset grant_cnt",    64'(grant_cnt),    64'h0);
      checkOutput("reset wb_reg_mask",  64'(wb_reg_mask),  64'h0);
      checkOutput("reset fu_wr_rdy",    64'(fu_wr_rdy),    64'h0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].vld, vecs[i].ids, vecs[i].data, vecs[i].rdy);
         #1;
         checkOutput($sformatf("v%0d fu_wr_rdy", i),   64'(fu_wr_rdy),   64'(vecs[i].e_rdy));
         checkOutput($sformatf("v%0d rf_wr_vld", i),   64'(rf_wr_vld),   64'(vecs[i].e_vld));
         checkOutput($sformatf("v%0d wb_reg_mask", i), 64'(wb_reg_mask), 64'(vecs[i].e_mask));
         checkOutput($sformatf("v%0d grant_cnt", i),   64'(grant_cnt),   64'(vecs[i].e_cnt));
         if (vecs[i].e_vld) begin
            checkOutput($sformatf("v%0d rf_wr_reg_id", i), 64'(rf_wr_reg_id), 64'(vecs[i].e_reg));
            checkOutput($sformatf("v%0d rf_wr_data", i),   64'(rf_wr_data),   64'(vecs[i].e_data));
            checkOutput($sformatf("v%0d rf_wr_fu", i),     64'(rf_wr_fu),     64'(vecs[i].e_fu));
         end
         @(negedge clk);
      end

      // asynchronous reset while an entry is stalled in the output stage
      applyStimulus(4'b0001, IDS_T5, DATA_T5, 1'b0);
      #1;
      checkOutput("rst-stall grant", 64'(fu_wr_rdy), 64'h1);
      @(negedge clk);
      applyStimulus(4'b0000, IDS_T5, DATA_T5, 1'b0);
      #1;
      checkOutput("rst-stall rf_wr_vld",    64'(rf_wr_vld),    64'h1);
      checkOutput("rst-stall rf_wr_reg_id", 64'(rf_wr_reg_id), 64'h3);
      checkOutput("rst-stall rf_wr_data",   64'(rf_wr_data),   64'hBEEF);
      checkOutput("rst-stall wb_reg_mask",  64'(wb_reg_mask),  64'h0);
      checkOutput("rst-stall grant_cnt",    64'(grant_cnt),    64'd10);
      rst_n = 1'b0;
      #1;
      checkOutput("async rst rf_wr_vld",   64'(rf_wr_vld),   64'h0);
      checkOutput("async rst grant_cnt",   64'(grant_cnt),   64'h0);
      checkOutput("async rst wb_reg_mask", 64'(wb_reg_mask), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b1111, IDS_ALL, DATA_ALL, 1'b1);
      #1;
      checkOutput("post-rst rr_ptr grant", 64'(fu_wr_rdy), 64'h1);
      #1;
      applyStimulus(4'b0000, IDS_ALL, DATA_ALL, 1'b1);

      // grant_cnt saturation: FU0 writes reg 1 every cycle
      @(negedge clk);
      applyStimulus(4'b0001, IDS_ALL, DATA_ALL, 1'b1);
      repeat (65535) @(negedge clk);
      #1;
      checkOutput("grant_cnt preload", 64'(grant_cnt), 64'hFFFE);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("grant_cnt saturate", 64'(grant_cnt), 64'hFFFF);
      checkOutput("saturate wb_reg_mask", 64'(wb_reg_mask), 64'h2);
      applyStimulus(4'b0000, IDS_ALL, DATA_ALL, 1'b1);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
